// File: rtl/dds_pkg.sv
// Shared types and helpers for the DDS voice scheduler: frame FSM states,
// amplitude midscale and slot-counter sizing.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int unsigned midscale(input int unsigned am_width);
    return 32'd1 << (am_width - 1);
  endfunction

  // A single-voice build still needs a one-bit slot counter.
  function automatic int unsigned slot_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// One voice's phase accumulator: adds its tuning word on step, clears on clr.
// Only the top THETA_WIDTH bits leave the block, as they form the ROM address.
module dds_phase_acc #(
  parameter int ACC_WIDTH   = 24,
  parameter int THETA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step,
  input  logic                   clr,
  input  logic [ACC_WIDTH-1:0]   ftw,
  output logic [THETA_WIDTH-1:0] phase
);

  logic [ACC_WIDTH-1:0] phase_q, phase_d;

  // Clear wins over step; the sum wraps modulo 2**ACC_WIDTH by design.
  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (step) begin
      phase_d = phase_q + ftw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q[ACC_WIDTH-1 -: THETA_WIDTH];

endmodule

// File: rtl/dds_voice_sched.sv
// Shares one 1-cycle-latency sine ROM among PLAYER_NUM voices: advances every
// phase accumulator on a sample tick, reads the ROM once per voice, then
// publishes all amplitudes together with a single am_valid strobe.
module dds_voice_sched
  import dds_pkg::*;
#(
  parameter int PLAYER_NUM  = 3,
  parameter int THETA_WIDTH = 8,
  parameter int AM_WIDTH    = 8,
  parameter int ACC_WIDTH   = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sample_tick,
  input  logic [PLAYER_NUM-1:0]          voice_en,
  input  logic [ACC_WIDTH*PLAYER_NUM-1:0] ftw,
  output logic                           rom_en,
  output logic [THETA_WIDTH-1:0]         rom_addr,
  input  logic [AM_WIDTH-1:0]            rom_data,
  output logic [AM_WIDTH*PLAYER_NUM-1:0] am,
  output logic                           am_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned         SLOT_W    = slot_width(PLAYER_NUM);
  localparam logic [AM_WIDTH-1:0] MID       = AM_WIDTH'(midscale(AM_WIDTH));
  localparam logic [SLOT_W-1:0]   LAST_SLOT = SLOT_W'(PLAYER_NUM - 1);

  state_t                          state_q, state_d;
  logic [SLOT_W-1:0]               slot_q, slot_d;
  logic [PLAYER_NUM-1:0]           en_q, en_d;
  logic [THETA_WIDTH-1:0]          addr_q, addr_d;
  logic [THETA_WIDTH-1:0]          sel_addr;
  logic [AM_WIDTH*PLAYER_NUM-1:0]  shadow_q, shadow_d;
  logic [AM_WIDTH*PLAYER_NUM-1:0]  am_q, am_d;
  logic                            am_valid_q, am_valid_d;
  logic                            overrun_q, overrun_d;
  logic                            tick_accept;
  logic [THETA_WIDTH-1:0]          phase [PLAYER_NUM];

  for (genvar g = 0; g < PLAYER_NUM; g++) begin : g_voice
    dds_phase_acc #(
      .ACC_WIDTH   (ACC_WIDTH),
      .THETA_WIDTH (THETA_WIDTH)
    ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (tick_accept & voice_en[g]),
      .clr   (tick_accept & ~voice_en[g]),
      .ftw   (ftw[ACC_WIDTH*g +: ACC_WIDTH]),
      .phase (phase[g])
    );
  end

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < PLAYER_NUM; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        sel_addr = phase[i];
      end
    end
  end

  // ROM data for slot k lands one cycle after its issue, so ISSUE k captures
  // voice k-1 and DRAIN captures the last voice straight into am as well.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    en_d        = en_q;
    addr_d      = addr_q;
    shadow_d    = shadow_q;
    am_d        = am_q;
    am_valid_d  = 1'b0;
    tick_accept = 1'b0;
    overrun_d   = sample_tick && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          tick_accept = 1'b1;
          en_d        = voice_en;
          slot_d      = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        addr_d = sel_addr;
        for (int i = 0; i < PLAYER_NUM - 1; i++) begin
          if (slot_q == SLOT_W'(i + 1)) begin
            shadow_d[AM_WIDTH*i +: AM_WIDTH] = en_q[i] ? rom_data : MID;
          end
        end
        if (slot_q == LAST_SLOT) begin
          state_d = DRAIN;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      DRAIN: begin
        shadow_d[AM_WIDTH*(PLAYER_NUM-1) +: AM_WIDTH] =
          en_q[PLAYER_NUM-1] ? rom_data : MID;
        am_d       = shadow_d;
        am_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      en_q       <= '0;
      addr_q     <= '0;
      shadow_q   <= {PLAYER_NUM{MID}};
      am_q       <= {PLAYER_NUM{MID}};
      am_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      shadow_q   <= shadow_d;
      am_q       <= am_d;
      am_valid_q <= am_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Address is live during ISSUE and otherwise holds the last slot issued.
  assign rom_en   = (state_q == ISSUE);
  assign rom_addr = rom_en ? sel_addr : addr_q;
  assign busy     = (state_q != IDLE);
  assign am       = am_q;
  assign am_valid = am_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_dds_voice_sched.sv
// Directed self-checking bench for dds_voice_sched with three voices and a
// behavioural 1-cycle-latency sine ROM (half-step offset table).
module tb_dds_voice_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic [2:0]  voice_en;
  logic [71:0] ftw;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [23:0] am;
  logic        am_valid;
  logic        busy;
  logic        overrun;

  logic [7:0]  tab [256];
  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;
  int          v0;

  logic [8:1]  obs_en, obs_busy, obs_valid, obs_ovr;
  logic [7:0]  obs_addr [1:8];
  logic [23:0] obs_am;

  localparam logic [71:0] FTW_DEF = {24'h040000, 24'h020000, 24'h010000};

  dds_voice_sched #(
    .PLAYER_NUM  (3),
    .THETA_WIDTH (8),
    .AM_WIDTH    (8),
    .ACC_WIDTH   (24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .voice_en    (voice_en),
    .ftw         (ftw),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .am          (am),
    .am_valid    (am_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_data <= tab[rom_addr];
  end

  always @(negedge clk) begin
    if (am_valid === 1'b1) valid_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Tick in cycle T, optional second tick in cycle T+extra, record T+1..T+8.
  task automatic run_frame(input int extra);
    sample_tick = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      sample_tick = (extra != 0) && (c == extra);
      obs_en[c]    = rom_en;
      obs_busy[c]  = busy;
      obs_valid[c] = am_valid;
      obs_ovr[c]   = overrun;
      obs_addr[c]  = rom_addr;
      if (c == 5) obs_am = am;
    end
    sample_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_tick = 1'b0; voice_en = 3'b000; ftw = '0;
    step(); step();
    checks++; if (am !== 24'h808080) begin errors++; $display("[TB] FAIL reset_am got %h expected %h", am, 24'h808080); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (rom_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_en got %b expected 0", rom_en); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_rom_addr got %h expected 00", rom_addr); end
    checks++; if ({am_valid, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes got %b expected 00", {am_valid, overrun}); end
    v0 = valid_cnt;
    rst_n = 1'b1;
    repeat (10) step();
    checks++; if (valid_cnt !== v0) begin errors++; $display("[TB] FAIL reset_no_valid got %0d expected %0d", valid_cnt, v0); end
  endtask

  task automatic test_single_frame();
    ftw = FTW_DEF; voice_en = 3'b111;
    step();
    run_frame(0);
    checks++; if ({obs_addr[1], obs_addr[2], obs_addr[3]} !== 24'h010204) begin errors++; $display("[TB] FAIL single_addr got %h expected 010204", {obs_addr[1], obs_addr[2], obs_addr[3]}); end
    checks++; if (obs_en !== 8'b00000111) begin errors++; $display("[TB] FAIL single_rom_en got %b expected 00000111", obs_en); end
    checks++; if (obs_busy !== 8'b00001111) begin errors++; $display("[TB] FAIL single_busy got %b expected 00001111", obs_busy); end
    checks++; if (obs_valid !== 8'b00010000) begin errors++; $display("[TB] FAIL single_valid got %b expected 00010000", obs_valid); end
    checks++; if (obs_am !== {tab[4], tab[2], tab[1]}) begin errors++; $display("[TB] FAIL single_am got %h expected %h", obs_am, {tab[4], tab[2], tab[1]}); end
    checks++; if (obs_ovr !== 8'h00) begin errors++; $display("[TB] FAIL single_overrun got %b expected 0", obs_ovr); end
  endtask

  task automatic test_wrap();
    do_reset();
    ftw = {24'h040000, 24'h020000, 24'h000001};
    run_frame(0);
    checks++; if (obs_addr[1] !== 8'h00) begin errors++; $display("[TB] FAIL wrap_preload_addr got %h expected 00", obs_addr[1]); end
    ftw[23:0] = 24'hFFFFFF;
    run_frame(0);
    checks++; if ({obs_addr[1], obs_addr[2], obs_addr[3]} !== 24'h000408) begin errors++; $display("[TB] FAIL wrap_addr got %h expected 000408", {obs_addr[1], obs_addr[2], obs_addr[3]}); end
    checks++; if ({obs_valid, obs_ovr} !== {8'b00010000, 8'h00}) begin errors++; $display("[TB] FAIL wrap_strobes got %b expected 0001000000000000", {obs_valid, obs_ovr}); end
    run_frame(0);
    checks++; if ({obs_addr[1], obs_addr[2], obs_addr[3]} !== 24'hFF060C) begin errors++; $display("[TB] FAIL wrap_after_addr got %h expected FF060C", {obs_addr[1], obs_addr[2], obs_addr[3]}); end
    checks++; if (obs_am !== {tab[8'h0C], tab[8'h06], tab[8'hFF]}) begin errors++; $display("[TB] FAIL wrap_am got %h expected %h", obs_am, {tab[8'h0C], tab[8'h06], tab[8'hFF]}); end
  endtask

  task automatic test_disable();
    do_reset();
    ftw = FTW_DEF; voice_en = 3'b101;
    run_frame(0);
    checks++; if ({obs_addr[1], obs_addr[2], obs_addr[3]} !== 24'h010004) begin errors++; $display("[TB] FAIL disable_addr got %h expected 010004", {obs_addr[1], obs_addr[2], obs_addr[3]}); end
    checks++; if (obs_en !== 8'b00000111) begin errors++; $display("[TB] FAIL disable_slot_read got %b expected 00000111", obs_en); end
    checks++; if (obs_am !== {tab[4], 8'h80, tab[1]}) begin errors++; $display("[TB] FAIL disable_am got %h expected %h", obs_am, {tab[4], 8'h80, tab[1]}); end
    voice_en = 3'b111;
    run_frame(0);
    checks++; if ({obs_addr[1], obs_addr[2], obs_addr[3]} !== 24'h020208) begin errors++; $display("[TB] FAIL reenable_addr got %h expected 020208", {obs_addr[1], obs_addr[2], obs_addr[3]}); end
    checks++; if (obs_am[15:8] !== tab[2]) begin errors++; $display("[TB] FAIL reenable_am1 got %h expected %h", obs_am[15:8], tab[2]); end
  endtask

  task automatic test_overrun();
    run_frame(2);
    checks++; if (obs_ovr !== 8'b00000100) begin errors++; $display("[TB] FAIL overrun_issue_pulse got %b expected 00000100", obs_ovr); end
    checks++; if (obs_valid !== 8'b00010000) begin errors++; $display("[TB] FAIL overrun_single_valid got %b expected 00010000", obs_valid); end
    checks++; if ({obs_addr[1], obs_addr[2], obs_addr[3]} !== 24'h03040C) begin errors++; $display("[TB] FAIL overrun_addr got %h expected 03040C", {obs_addr[1], obs_addr[2], obs_addr[3]}); end
    run_frame(4);
    checks++; if (obs_ovr !== 8'b00010000) begin errors++; $display("[TB] FAIL overrun_drain_pulse got %b expected 00010000", obs_ovr); end
    checks++; if ({obs_addr[1], obs_addr[2], obs_addr[3]} !== 24'h040610) begin errors++; $display("[TB] FAIL overrun_drain_addr got %h expected 040610", {obs_addr[1], obs_addr[2], obs_addr[3]}); end
    run_frame(0);
    checks++; if ({obs_addr[1], obs_addr[2], obs_addr[3]} !== 24'h050814) begin errors++; $display("[TB] FAIL overrun_single_advance got %h expected 050814", {obs_addr[1], obs_addr[2], obs_addr[3]}); end
  endtask

  task automatic test_back_to_back();
    run_frame(5);
    checks++; if (obs_ovr !== 8'h00) begin errors++; $display("[TB] FAIL b2b_overrun got %b expected 0", obs_ovr); end
    checks++; if (obs_en !== 8'b11100111) begin errors++; $display("[TB] FAIL b2b_rom_en got %b expected 11100111", obs_en); end
    checks++; if (obs_busy !== 8'b11101111) begin errors++; $display("[TB] FAIL b2b_busy got %b expected 11101111", obs_busy); end
    checks++; if ({obs_addr[6], obs_addr[7], obs_addr[8]} !== 24'h070C1C) begin errors++; $display("[TB] FAIL b2b_second_addr got %h expected 070C1C", {obs_addr[6], obs_addr[7], obs_addr[8]}); end
    step(); step();
    checks++; if (am_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_valid got %b expected 1", am_valid); end
    checks++; if (am !== {tab[8'h1C], tab[8'h0C], tab[8'h07]}) begin errors++; $display("[TB] FAIL b2b_second_am got %h expected %h", am, {tab[8'h1C], tab[8'h0C], tab[8'h07]}); end
    step();
  endtask

  task automatic test_reset_mid_frame();
    ftw = FTW_DEF; voice_en = 3'b111;
    v0 = valid_cnt;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, rom_en} !== 2'b00) begin errors++; $display("[TB] FAIL midreset_busy_en got %b expected 00", {busy, rom_en}); end
    checks++; if (am !== 24'h808080) begin errors++; $display("[TB] FAIL midreset_am got %h expected 808080", am); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("[TB] FAIL midreset_rom_addr got %h expected 00", rom_addr); end
    step(); step();
    rst_n = 1'b1;
    repeat (6) step();
    checks++; if (valid_cnt !== v0) begin errors++; $display("[TB] FAIL midreset_no_valid got %0d expected %0d", valid_cnt, v0); end
    run_frame(0);
    checks++; if ({obs_addr[1], obs_addr[2], obs_addr[3]} !== 24'h010204) begin errors++; $display("[TB] FAIL midreset_restart_addr got %h expected 010204", {obs_addr[1], obs_addr[2], obs_addr[3]}); end
    checks++; if (obs_am !== {tab[4], tab[2], tab[1]}) begin errors++; $display("[TB] FAIL midreset_restart_am got %h expected %h", obs_am, {tab[4], tab[2], tab[1]}); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tab[i] = 8'($rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * (real'(i) + 0.5) / 256.0) + 0.5));
    end
    rst_n = 1'b0;
    sample_tick = 1'b0;
    voice_en = 3'b000;
    ftw = '0;
    test_reset();
    test_single_frame();
    test_wrap();
    test_disable();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
